// File: rtl/commit_checker.sv
// Retirement-stream checker: verifies PC continuity, counts retirements, detects the
// end-of-test self-loop and buffers retired PCs in a trace FIFO for a host to drain.
module commit_checker #(
    parameter int PC_WIDTH  = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [PC_WIDTH-1:0]  start_pc_i,
    input  logic                 clr_i,
    input  logic                 commit_i,
    input  logic [PC_WIDTH-1:0]  commit_pc_i,
    input  logic [PC_WIDTH-1:0]  commit_pre_pc_i,
    output logic                 trace_valid_o,
    input  logic                 trace_ready_i,
    output logic [PC_WIDTH-1:0]  trace_pc_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [PC_WIDTH-1:0]  err_pc_o,
    output logic [PC_WIDTH-1:0]  err_exp_pc_o,
    output logic [CNT_WIDTH-1:0] commit_cnt_o,
    output logic                 overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // One-hot encoding so the status outputs are plain flop bits.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DONE  = 4'b0100,
        S_ERROR = 4'b1000
    } state_t;

    state_t state, state_nxt;

    logic                do_start, do_clr, accept, mismatch;
    logic [PC_WIDTH-1:0] exp_pc;

    logic [PC_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                full, pop, push, drop;

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_clr    = 1'b0;
        accept    = 1'b0;
        mismatch  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    do_start  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (commit_i) begin
                    if (commit_pc_i == exp_pc) begin
                        accept = 1'b1;
                        if (commit_pre_pc_i == commit_pc_i) state_nxt = S_DONE;
                    end else begin
                        mismatch  = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (clr_i) begin
                    do_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_o = state[1];
    assign done_o = state[2];
    assign err_o  = state[3];

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            exp_pc       <= '0;
            commit_cnt_o <= '0;
            err_pc_o     <= '0;
            err_exp_pc_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (do_start) begin
                exp_pc       <= start_pc_i;
                commit_cnt_o <= '0;
                overflow_o   <= 1'b0;
            end
            if (accept) begin
                exp_pc <= commit_pre_pc_i;
                if (commit_cnt_o != '1) commit_cnt_o <= commit_cnt_o + CNT_WIDTH'(1);
            end
            if (drop) overflow_o <= 1'b1;
            if (mismatch) begin
                err_pc_o     <= commit_pc_i;
                err_exp_pc_o <= exp_pc;
            end
            if (do_clr) begin
                commit_cnt_o <= '0;
                err_pc_o     <= '0;
                err_exp_pc_o <= '0;
                overflow_o   <= 1'b0;
            end
        end
    end

    // A push into a full FIFO still succeeds when the head leaves on the same edge.
    assign full          = (count == FULL_CNT);
    assign trace_valid_o = (count != '0);
    assign pop           = trace_valid_o & trace_ready_i;
    assign push          = accept & (~full | pop);
    assign drop          = accept & full & ~pop;
    assign trace_pc_o    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= commit_pc_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_checker.sv
// Randomised and directed bench for commit_checker against a queue-based reference model.
module tb_commit_checker;

    localparam int PW      = 32;
    localparam int DEPTH   = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;
    localparam int M_ERROR = 3;

    logic          clk_i = 1'b0;
    logic          rst   = 1'b0;
    logic          start_i = 1'b0, clr_i = 1'b0, commit_i = 1'b0, trace_ready_i = 1'b0;
    logic [PW-1:0] start_pc_i = '0, commit_pc_i = '0, commit_pre_pc_i = '0;
    logic          trace_valid_o, busy_o, done_o, err_o, overflow_o;
    logic [PW-1:0] trace_pc_o, err_pc_o, err_exp_pc_o;
    logic [CW-1:0] commit_cnt_o;

    commit_checker #(.PC_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst(rst), .start_i(start_i), .start_pc_i(start_pc_i),
        .clr_i(clr_i), .commit_i(commit_i), .commit_pc_i(commit_pc_i),
        .commit_pre_pc_i(commit_pre_pc_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .err_pc_o(err_pc_o), .err_exp_pc_o(err_exp_pc_o),
        .commit_cnt_o(commit_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    int            m_state;
    logic [PW-1:0] m_exp, m_err_pc, m_err_exp;
    int            m_cnt;
    bit            m_ovf;
    logic [PW-1:0] exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_exp = '0; m_err_pc = '0; m_err_exp = '0;
        m_cnt = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic model_update();
        bit pop, do_clr, push_req;
        pop      = (exp_q.size() != 0) && trace_ready_i;
        do_clr   = 0;
        push_req = 0;
        case (m_state)
            M_IDLE: if (start_i) begin
                m_state = M_RUN; m_exp = start_pc_i; m_cnt = 0; m_ovf = 0;
            end
            M_RUN: if (commit_i) begin
                if (commit_pc_i == m_exp) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_exp    = commit_pre_pc_i;
                    push_req = 1;
                    if (commit_pre_pc_i == commit_pc_i) m_state = M_DONE;
                end else begin
                    m_state   = M_ERROR;
                    m_err_pc  = commit_pc_i;
                    m_err_exp = m_exp;
                end
            end
            default: if (clr_i) begin
                do_clr = 1; m_state = M_IDLE; m_cnt = 0;
                m_err_pc = '0; m_err_exp = '0; m_ovf = 0;
            end
        endcase
        if (do_clr) exp_q.delete();
        else begin
            if (pop) void'(exp_q.pop_front());
            if (push_req) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(commit_pc_i);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("busy", busy_o, m_state == M_RUN);
        check("done", done_o, m_state == M_DONE);
        check("err", err_o, m_state == M_ERROR);
        check("err_pc", err_pc_o, m_err_pc);
        check("err_exp_pc", err_exp_pc_o, m_err_exp);
        check("commit_cnt", commit_cnt_o, m_cnt);
        check("overflow", overflow_o, m_ovf);
        check("trace_valid", trace_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) check("trace_pc", trace_pc_o, exp_q[0]);
    endtask

    // Drive at the falling edge, advance the model at the rising edge, compare 1 ns later.
    task automatic drive(input logic st, input logic [PW-1:0] spc, input logic cl,
                         input logic cm, input logic [PW-1:0] pc, input logic [PW-1:0] pre,
                         input logic rdy);
        @(negedge clk_i);
        start_i = st; start_pc_i = spc; clr_i = cl; commit_i = cm;
        commit_pc_i = pc; commit_pre_pc_i = pre; trace_ready_i = rdy;
        @(posedge clk_i);
        model_update();
        #1 compare_all();
    endtask

    task automatic do_commit(input logic [PW-1:0] pc, input logic [PW-1:0] pre, input logic rdy);
        drive(1'b0, $urandom, 1'b0, 1'b1, pc, pre, rdy);
    endtask

    task automatic do_bubble(input logic rdy);
        drive(1'b0, $urandom, 1'b0, 1'b0, $urandom, $urandom, rdy);
    endtask

    task automatic do_start(input logic [PW-1:0] spc);
        drive(1'b1, spc, 1'b0, 1'b0, $urandom, $urandom, 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, $urandom, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
    endtask

    // Reset is applied between clock edges to exercise the asynchronous path.
    task automatic apply_reset();
        @(negedge clk_i);
        #2 rst = 1'b0;
        start_i = 0; clr_i = 0; commit_i = 0; trace_ready_i = 0;
        #1 model_reset();
        compare_all();
        check("reset_trace_pc", trace_pc_o, 0);
        @(negedge clk_i);
        rst = 1'b1;
    endtask

    task automatic drain_count(input int budget, output int pops);
        pops = 0;
        for (int i = 0; i < budget; i++) begin
            if (trace_valid_o) pops++;
            do_bubble(1'b1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int r;
        logic [PW-1:0] pc;
        model_reset();
        apply_reset();

        // Three sequential retirements ending in a self-loop
        do_start(32'h8000_0000);
        do_commit(32'h8000_0000, 32'h8000_0004, 1'b0);
        do_commit(32'h8000_0004, 32'h8000_0008, 1'b0);
        do_commit(32'h8000_0008, 32'h8000_0008, 1'b0);
        check("t1_done", done_o, 1);
        check("t1_cnt", commit_cnt_o, 3);
        check("t1_head0", trace_pc_o, 32'h8000_0000);
        do_bubble(1'b1);
        check("t1_head1", trace_pc_o, 32'h8000_0004);
        do_bubble(1'b1);
        check("t1_head2", trace_pc_o, 32'h8000_0008);
        do_bubble(1'b1);
        check("t1_empty", trace_valid_o, 0);
        do_commit(32'h8000_000c, 32'h8000_0010, 1'b0);
        check("t1_ignored_in_done", commit_cnt_o, 3);
        do_clear();
        check("t1_clr_cnt", commit_cnt_o, 0);

        // Discontinuity, with a start pulse and bubbles in RUN that must be ignored
        do_start(32'h1000);
        do_bubble(1'b0);
        drive(1'b1, 32'hdead_0000, 1'b0, 1'b0, 32'h5555, 32'h7777, 1'b0);
        do_commit(32'h1000, 32'h1004, 1'b0);
        do_bubble(1'b0);
        do_commit(32'h1010, 32'h1014, 1'b0);
        check("t2_err", err_o, 1);
        check("t2_err_pc", err_pc_o, 32'h1010);
        check("t2_err_exp", err_exp_pc_o, 32'h1004);
        check("t2_cnt", commit_cnt_o, 1);
        drain_count(4, pops);
        check("t2_entries", pops, 1);
        do_clear();
        check("t2_clr_err_pc", err_pc_o, 0);

        // Overflow: 10 commits with no drain
        do_start(32'h2000);
        for (int i = 0; i < 10; i++) do_commit(32'h2000 + 4 * i, 32'h2004 + 4 * i, 1'b0);
        check("t3_overflow", overflow_o, 1);
        check("t3_cnt", commit_cnt_o, 10);
        drain_count(16, pops);
        check("t3_pops", pops, 8);
        do_commit(32'h2028, 32'h2028, 1'b1);
        do_bubble(1'b1);
        do_clear();
        check("t3_clr_ovf", overflow_o, 0);

        // Full FIFO with a simultaneous pop and push
        do_start(32'h3000);
        for (int i = 0; i < 8; i++) do_commit(32'h3000 + 4 * i, 32'h3004 + 4 * i, 1'b0);
        do_commit(32'h3020, 32'h3024, 1'b1);
        check("t4_no_overflow", overflow_o, 0);
        check("t4_head", trace_pc_o, 32'h3004);
        drain_count(16, pops);
        check("t4_pops", pops, 8);

        // Reset mid-RUN with three entries queued
        do_start(32'h0);
        do_clear();
        apply_reset();
        do_start(32'h4000);
        for (int i = 0; i < 3; i++) do_commit(32'h4000 + 4 * i, 32'h4004 + 4 * i, 1'b0);
        apply_reset();
        check("t5_valid_after_rst", trace_valid_o, 0);

        // Counter saturation
        do_start(32'h5000);
        for (int i = 0; i < 18; i++) do_commit(32'h5000 + 4 * i, 32'h5004 + 4 * i, 1'b1);
        check("t6_sat", commit_cnt_o, CNT_MAX);
        do_commit(32'h5048, 32'h5048, 1'b1);
        check("t6_sat_done", commit_cnt_o, CNT_MAX);
        do_clear();

        // Randomised phase
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            case (m_state)
                M_IDLE: begin
                    if (r < 30) drive(1'b1, $urandom & 32'hffff_fffc, $urandom_range(0, 1), 1'b1,
                                      $urandom, $urandom, $urandom_range(0, 1));
                    else drive(1'b0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                               $urandom, $urandom, $urandom_range(0, 1));
                end
                M_RUN: begin
                    pc = m_exp;
                    if (r < 20)
                        drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b0,
                              $urandom, $urandom, $urandom_range(0, 1));
                    else if (r < 22)
                        do_commit(pc ^ ($urandom_range(1, 255) << 2), pc + 4, $urandom_range(0, 1));
                    else if (r < 25)
                        do_commit(pc, pc, $urandom_range(0, 1));
                    else if (r < 30)
                        do_commit(pc, $urandom & 32'hffff_fffc, $urandom_range(0, 1));
                    else
                        do_commit(pc, pc + 4, $urandom_range(0, 3) != 0);
                end
                default: begin
                    drive($urandom_range(0, 1), $urandom, r < 15, $urandom_range(0, 1),
                          $urandom, $urandom, $urandom_range(0, 1));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
